// File: rtl/enc_pkg.sv
// Shared types and the quadrature step decoder for the encoder front-end.
package enc_pkg;

  typedef logic [1:0] quad_t;  // {A, B}

  typedef enum logic {INIT, RUN} enc_state_t;

  typedef struct packed {
    logic valid;    // any change between prev and cur
    logic dir;      // 1 = +1 step
    logic illegal;  // both phases changed
  } step_t;

  localparam logic [7:0] OVERRUN_MAX = 8'hFF;

  // Gray code 00,01,11,10 maps to index 0..3 as {A, A^B}; the index delta gives the step.
  function automatic step_t quad_step(input quad_t prev, input quad_t cur);
    logic [1:0] idx_prev;
    logic [1:0] idx_cur;
    logic [1:0] delta;
    step_t      s;
    idx_prev  = {prev[1], prev[1] ^ prev[0]};
    idx_cur   = {cur[1], cur[1] ^ cur[0]};
    delta     = idx_cur - idx_prev;
    s.valid   = (delta != 2'd0);
    s.dir     = (delta == 2'd1);
    s.illegal = (delta == 2'd2);
    return s;
  endfunction

endpackage

// File: rtl/phase_glitch_filter.sv
// One encoder phase: multi-stage synchroniser followed by a consecutive-mismatch glitch filter.
module phase_glitch_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_in,
  input  logic load_in,
  output logic sync_out,
  output logic filt_out
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q, filt_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (load_in) begin
      filt_d = sync_bit;
    end else if (sync_bit != filt_q) begin
      // The FILTER_LEN-th consecutive mismatch commits the new level.
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        filt_d = sync_bit;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_out = sync_bit;
  assign filt_out = filt_q;

endmodule

// File: rtl/quadrature_encoder_irq.sv
// Quadrature encoder front-end: filtered phases, signed position, direction, level IRQ,
// sticky illegal-transition flag and saturating overrun count.
module quadrature_encoder_irq
  import enc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               EncPhA_in,
  input  logic               EncPhB_in,
  input  logic               irq_ack_in,
  input  logic               count_clr_in,
  output logic [COUNT_W-1:0] position_out,
  output logic               direction_out,
  output logic               irq_out,
  output logic               error_out,
  output logic [7:0]         overrun_out,
  output logic               filtA_out,
  output logic               filtB_out
);

  localparam int unsigned InitLen = SYNC_STAGES + FILTER_LEN;
  localparam int unsigned InitW   = $clog2(InitLen + 1);

  enc_state_t state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic init_done, init_load, run_en;

  quad_t sync_pair, filt_pair, prev_q, prev_d;
  step_t step;

  logic [COUNT_W-1:0] position_q, position_d;
  logic               direction_q, direction_d;
  logic               irq_q, irq_d;
  logic               error_q, error_d;
  logic [7:0]         overrun_q, overrun_d;

  phase_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt_a (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .raw_in  (EncPhA_in),
    .load_in (init_load),
    .sync_out(sync_pair[1]),
    .filt_out(filt_pair[1])
  );

  phase_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt_b (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .raw_in  (EncPhB_in),
    .load_in (init_load),
    .sync_out(sync_pair[0]),
    .filt_out(filt_pair[0])
  );

  assign init_done = (init_cnt_q == InitW'(InitLen - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (init_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    init_load = (state_q == INIT);
    run_en    = (state_q == RUN);
  end

  always_comb begin
    init_cnt_d = init_cnt_q;
    if (init_load && !init_done) init_cnt_d = init_cnt_q + InitW'(1);

    step = quad_step(prev_q, filt_pair);
    if (!run_en) step = '0;
    // During INIT the filters load the synchronisers, so track that same pair.
    prev_d = init_load ? sync_pair : filt_pair;

    position_d  = position_q;
    direction_d = direction_q;
    error_d     = error_q;
    overrun_d   = overrun_q;
    irq_d       = irq_q;

    if (step.valid && !step.illegal) begin
      position_d  = step.dir ? position_q + COUNT_W'(1) : position_q - COUNT_W'(1);
      direction_d = step.dir;
    end
    if (step.illegal) error_d = 1'b1;

    // A new event beats a same-cycle acknowledge.
    if (step.valid) begin
      irq_d = 1'b1;
    end else if (irq_ack_in) begin
      irq_d = 1'b0;
    end

    if (step.valid && irq_q && !irq_ack_in && (overrun_q != OVERRUN_MAX)) begin
      overrun_d = overrun_q + 8'd1;
    end

    if (count_clr_in) begin
      position_d = '0;
      error_d    = 1'b0;
      overrun_d  = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      init_cnt_q  <= '0;
      prev_q      <= '0;
      position_q  <= '0;
      direction_q <= 1'b0;
      irq_q       <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= '0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      prev_q      <= prev_d;
      position_q  <= position_d;
      direction_q <= direction_d;
      irq_q       <= irq_d;
      error_q     <= error_d;
      overrun_q   <= overrun_d;
    end
  end

  assign position_out  = position_q;
  assign direction_out = direction_q;
  assign irq_out       = irq_q;
  assign error_out     = error_q;
  assign overrun_out   = overrun_q;
  assign filtA_out     = filt_pair[1];
  assign filtB_out     = filt_pair[0];

endmodule

// File: tb/tb_quadrature_encoder_irq.sv
// Self-checking bench for quadrature_encoder_irq: vector table plus corner-case sequences.
module tb_quadrature_encoder_irq;

  localparam int unsigned S   = 2;
  localparam int unsigned F   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = S + F + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic ack = 1'b0;
  logic clr = 1'b0;

  logic [W-1:0] pos;
  logic         dir, irq, err, fa, fb;
  logic [7:0]   ovr;

  always #5 clk = ~clk;

  quadrature_encoder_irq #(
    .SYNC_STAGES(S),
    .FILTER_LEN (F),
    .COUNT_W    (W)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .EncPhA_in    (enc_a),
    .EncPhB_in    (enc_b),
    .irq_ack_in   (ack),
    .count_clr_in (clr),
    .position_out (pos),
    .direction_out(dir),
    .irq_out      (irq),
    .error_out    (err),
    .overrun_out  (ovr),
    .filtA_out    (fa),
    .filtB_out    (fb)
  );

  typedef struct {
    logic [W-1:0] pos;
    logic         dir;
    logic         irq;
    logic         err;
    logic [7:0]   ovr;
  } exp_t;

  typedef struct {
    logic [1:0]   pins;
    logic         ack;
    logic [W-1:0] pos;
    logic         dir;
    logic         irq;
    logic         err;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[7];
  logic [1:0] gray[4];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_pos"}, pos, e.pos);
      chk({name, "_dir"}, dir, e.dir);
      chk({name, "_irq"}, irq, e.irq);
      chk({name, "_err"}, err, e.err);
      chk({name, "_ovr"}, ovr, e.ovr);
    end
  endtask

  task automatic drive_pins(input logic [1:0] p);
    @(posedge clk);
    #1;
    enc_a = p[1];
    enc_b = p[0];
  endtask

  task automatic ack_pulse(input string name);
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk(name, irq, 0);
  endtask

  task automatic apply_vec(input vec_t v, input int k, input logic [W-1:0] prev_pos);
    exp_t e;
    drive_pins(v.pins);
    e = '{v.pos, v.dir, v.irq, v.err, 8'd0};
    sb.push_back(e);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk($sformatf("vec%0d_early_irq", k), irq, 0);
    chk($sformatf("vec%0d_early_pos", k), pos, prev_pos);
    @(posedge clk);
    #1;
    pop_check($sformatf("vec%0d", k));
    if (v.ack) begin
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      chk($sformatf("vec%0d_ack", k), irq, 0);
    end
    repeat (12) @(posedge clk);
  endtask

  initial begin
    #200_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    logic [W-1:0] prev_pos;
    exp_t e;

    gray[0] = 2'b00;
    gray[1] = 2'b01;
    gray[2] = 2'b11;
    gray[3] = 2'b10;

    vecs[0] = '{2'b10, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 1'b1, 32'd3, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'b00, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b11, 1'b0, 32'd2, 1'b0, 1'b1, 1'b1};

    // Reset held with pins at 11.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos", pos, 0);
    chk("rst_irq", irq, 0);
    chk("rst_fa", fa, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("init_irq", irq, 0);
    chk("init_err", err, 0);
    chk("init_pos", pos, 0);
    chk("init_fa", fa, 1);
    chk("init_fb", fb, 1);

    prev_pos = '0;
    for (int k = 0; k < 7; k++) begin
      apply_vec(vecs[k], k, prev_pos);
      prev_pos = vecs[k].pos;
    end

    // Clear leaves a pending irq alone.
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_pos", pos, 0);
    chk("clr_ovr", ovr, 0);
    chk("clr_irq", irq, 1);
    ack_pulse("clr_ack");

    // Three-cycle glitch on A must be rejected.
    @(posedge clk);
    #1 enc_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("glitch_fa", fa, 1);
    chk("glitch_pos", pos, 0);
    chk("glitch_irq", irq, 0);

    // Backward step from zero wraps.
    idx = 1;
    drive_pins(gray[idx]);
    e = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 8'd0};
    sb.push_back(e);
    repeat (LAT) @(posedge clk);
    #1;
    pop_check("wrap");
    ack_pulse("wrap_ack");

    // 300 forward steps, never acked.
    for (int n = 0; n < 300; n++) begin
      idx = (idx + 1) % 4;
      drive_pins(gray[idx]);
      repeat (7) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    #1;
    e = '{32'd299, 1'b1, 1'b1, 1'b0, 8'd255};
    sb.push_back(e);
    pop_check("ovr");

    // Step landing on the same edge as an ack keeps irq set.
    idx = (idx + 1) % 4;
    drive_pins(gray[idx]);
    e = '{32'd300, 1'b1, 1'b1, 1'b0, 8'd255};
    sb.push_back(e);
    repeat (LAT - 1) @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    pop_check("coincide");
    @(posedge clk);
    #1;
    chk("coincide_hold", irq, 1);
    ack_pulse("coincide_ack");

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pos", pos, 0);
    chk("arst_dir", dir, 0);
    chk("arst_fa", fa, 0);
    chk("arst_ovr", ovr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rerun_irq", irq, 0);
    chk("rerun_err", err, 0);
    chk("rerun_pos", pos, 0);
    chk("rerun_fa", fa, gray[idx][1]);
    chk("rerun_fb", fb, gray[idx][0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
